mpeg_muxer: RTL and testbench
=============================

Name: mpeg_muxer

Overview:
- MPEG-1 system stream packetizer: wraps elementary-stream (ES) payload bytes into one pack header plus one PES packet per `start` request.
- Emits a byte stream with a valid/ready handshake.
- Sits opposite the demuxer: it produces streams for loopback verification and for re-muxing decoded ES data in the MPEG path.
- Inserts SCR, mux rate, optional PTS and PES length.

Parameters:
- STREAM_ID, 8'hE0, PES stream_id byte.
- PAYLOAD_LEN, 16'd2028, ES payload bytes per PES packet. Legal range 1..65529; an elaboration-time check rejects anything outside it.
- MUX_RATE, 22'd3528, pack mux_rate field, in units of 50 bytes/s.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  pulse: begin one pack+PES; ignored while busy
- scr  in  33  system clock reference, 90 kHz; sampled on start
- pts  in  33  presentation time stamp; sampled on start
- pts_valid  in  1  sampled on start; 1 = PTS field emitted
- es_data  in  8  ES payload byte
- es_valid  in  1  ES byte available
- es_ready  out  1  ES byte consumed this cycle
- out_data  out  8  system stream byte
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts
- busy  out  1  packet in progress
- packet_done  out  1  one-cycle pulse after the final payload handshake
- end_stream  in  1  request program end code; used only with the optional feature

Behaviour:
- Reset: state IDLE. out_valid=0, es_ready=0, busy=0, packet_done=0, byte index 0.
  - Reset mid-packet aborts immediately; no partial bytes follow.
- IDLE + start: latch scr, pts, pts_valid; go to PACK_SC; busy=1 from the next cycle.
- States and byte sequences (byte index counter resets on each state entry):
  - PACK_SC: 00 00 01 BA.
  - PACK_BODY (8 bytes):
    - {0010,scr[32:30],1}, scr[29:22], {scr[21:15],1}, scr[14:7], {scr[6:0],1}
    - {1,MUX_RATE[21:15]}, MUX_RATE[14:7], {MUX_RATE[6:0],1}
  - PES_SC: 00 00 01 STREAM_ID.
  - PES_LEN: hi, lo of PAYLOAD_LEN+5 if pts_valid, else PAYLOAD_LEN+1. Computed in 16 bits.
  - PES_TS:
    - pts_valid=1: {0010,pts[32:30],1}, pts[29:22], {pts[21:15],1}, pts[14:7], {pts[6:0],1}.
    - pts_valid=0: single byte 0F.
  - PAYLOAD: exactly PAYLOAD_LEN bytes, then IDLE with packet_done pulsed.
- Header states:
  - out_valid=1; out_data is driven from state and byte index.
  - A byte advances only on out_valid&&out_ready.
  - out_data stays stable while stalled; es_ready=0.
- PAYLOAD state (zero-latency pass-through):
  - out_data=es_data, out_valid=es_valid, es_ready=out_ready.
  - The payload counter decrements on es_valid&&out_ready.
  - An es_valid gap drops out_valid with no byte lost.
- packet_done: asserted the cycle after the last payload handshake; busy falls in that same cycle.
- start asserted in the same cycle as packet_done (IDLE) is accepted.
- Timestamps are never modified, only bit-sliced; markers are fixed 1.

Optional Feature:
- Macro MPEG_MUXER_END_CODE_EN.
- Defined: end_stream pulsed in IDLE emits 00 00 01 B9 via state END_CODE, with busy=1 during it.
  - start in the same cycle takes priority; end_stream is then ignored.
- Undefined: end_stream is ignored and END_CODE does not exist.

Decomposition:
- Package mpeg_pkg holds:
  - the start-code prefix and code constants: PACK 8'hBA, END 8'hB9, PES audio C0-DF, video E0-EF;
  - the muxer state enum;
  - function ts_byte(ts[32:0], idx, prefix[3:0]) that returns the 5-byte marker-encoded timestamp byte. It is shared by SCR and PTS.
- No sub-module; the single FSM is ~200 lines.

Test Plan:
- Test 1, SCR and PTS zero: PAYLOAD_LEN=4, scr=0, pts=0, pts_valid=1, ES AA BB CC DD, out_ready=1 → output
  00 00 01 BA 21 00 01 00 01 80 1B 91 00 00 01 E0 00 09 21 00 01 00 01 AA BB CC DD; packet_done pulses once.
- Test 2, PTS encoding: pts=90000, pts_valid=1 → PTS bytes 21 00 05 BF 21.
- Test 3, no PTS: pts_valid=0, PAYLOAD_LEN=4 → PES_LEN 00 05, then 0F, then the 4 payload bytes.
- Test 4, backpressure: out_ready=0 for 3 cycles on pack byte 4 → out_data held at 21 with out_valid=1. Also es_valid toggled 1-0-1 in PAYLOAD → no byte duplicated or dropped.
- Test 5, reset mid-payload: reset after 2 payload bytes → next cycle out_valid=0, busy=0. A following start produces a fresh pack header beginning 00 00 01 BA.
- Test 6, end code: with MPEG_MUXER_END_CODE_EN, end_stream in IDLE → 00 00 01 B9 emitted, then busy=0. Loop the muxer output into the demuxer and check that its PES PTS matches the injected PTS.

Source files
------------

// File: rtl/mpeg_pkg.sv
// Shared constants, state enum and timestamp encoder for the MPEG-1 system muxer.
// ST_END_CODE exists only when MPEG_MUXER_END_CODE_EN is defined.
package mpeg_pkg;

    localparam logic [7:0] SC_PREFIX0     = 8'h00;
    localparam logic [7:0] SC_PREFIX1     = 8'h00;
    localparam logic [7:0] SC_PREFIX2     = 8'h01;
    localparam logic [7:0] PACK_CODE      = 8'hBA;
    localparam logic [7:0] END_CODE_BYTE  = 8'hB9;
    localparam logic [7:0] PES_AUDIO_MIN  = 8'hC0;
    localparam logic [7:0] PES_AUDIO_MAX  = 8'hDF;
    localparam logic [7:0] PES_VIDEO_MIN  = 8'hE0;
    localparam logic [7:0] PES_VIDEO_MAX  = 8'hEF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PACK_SC,
        ST_PACK_BODY,
        ST_PES_SC,
        ST_PES_LEN,
        ST_PES_TS,
        ST_PAYLOAD
`ifdef MPEG_MUXER_END_CODE_EN
        , ST_END_CODE
`endif
    } mux_state_t;

    // Byte idx (0..4) of a 33-bit timestamp with its fixed marker bits.
    function automatic logic [7:0] ts_byte(input logic [32:0] ts, input logic [2:0] idx,
                                           input logic [3:0] prefix);
        case (idx)
            3'd0:    ts_byte = {prefix, ts[32:30], 1'b1};
            3'd1:    ts_byte = ts[29:22];
            3'd2:    ts_byte = {ts[21:15], 1'b1};
            3'd3:    ts_byte = ts[14:7];
            default: ts_byte = {ts[6:0], 1'b1};
        endcase
    endfunction

endpackage

// File: rtl/mpeg_muxer.sv
// MPEG-1 system stream packetizer: one pack header plus one PES packet per start.
// Optional program end code generation is enabled by MPEG_MUXER_END_CODE_EN.
module mpeg_muxer
    import mpeg_pkg::*;
#(
    parameter logic [7:0]  STREAM_ID   = 8'hE0,
    parameter logic [15:0] PAYLOAD_LEN = 16'd2028,
    parameter logic [21:0] MUX_RATE    = 22'd3528
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [32:0] scr,
    input  logic [32:0] pts,
    input  logic        pts_valid,
    input  logic [7:0]  es_data,
    input  logic        es_valid,
    output logic        es_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        packet_done,
    input  logic        end_stream
);

    generate
        if (PAYLOAD_LEN < 16'd1 || PAYLOAD_LEN > 16'd65529) begin : g_bad_len
            $error("mpeg_muxer: PAYLOAD_LEN out of range 1..65529");
        end
        if (!((STREAM_ID >= PES_AUDIO_MIN && STREAM_ID <= PES_AUDIO_MAX) ||
              (STREAM_ID >= PES_VIDEO_MIN && STREAM_ID <= PES_VIDEO_MAX))) begin : g_odd_id
            $warning("mpeg_muxer: STREAM_ID is not an audio or video stream id");
        end
    endgenerate

    mux_state_t  r_state;
    logic [2:0]  r_idx;
    logic [15:0] r_count;
    logic [32:0] r_scr;
    logic [32:0] r_pts;
    logic        r_pts_valid;
    logic        r_busy;
    logic        r_packet_done;

    logic [7:0]  w_hdr_byte;
    logic [2:0]  w_last_idx;
    mux_state_t  w_next;
    logic [15:0] w_pes_len;
    logic        w_hs;

`ifndef MPEG_MUXER_END_CODE_EN
    logic w_unused_end_stream;
    assign w_unused_end_stream = end_stream;
`endif

    assign w_pes_len = r_pts_valid ? (PAYLOAD_LEN + 16'd5) : (PAYLOAD_LEN + 16'd1);

    // Header byte, final index and successor are all pure functions of state and index.
    always_comb begin
        w_hdr_byte = 8'h00;
        w_last_idx = 3'd0;
        w_next     = ST_IDLE;
        case (r_state)
            ST_PACK_SC: begin
                w_hdr_byte = (r_idx == 3'd2) ? SC_PREFIX2 :
                             (r_idx == 3'd3) ? PACK_CODE  : SC_PREFIX0;
                w_last_idx = 3'd3;
                w_next     = ST_PACK_BODY;
            end
            ST_PACK_BODY: begin
                case (r_idx)
                    3'd5:    w_hdr_byte = {1'b1, MUX_RATE[21:15]};
                    3'd6:    w_hdr_byte = MUX_RATE[14:7];
                    3'd7:    w_hdr_byte = {MUX_RATE[6:0], 1'b1};
                    default: w_hdr_byte = ts_byte(r_scr, r_idx, 4'b0010);
                endcase
                w_last_idx = 3'd7;
                w_next     = ST_PES_SC;
            end
            ST_PES_SC: begin
                w_hdr_byte = (r_idx == 3'd2) ? SC_PREFIX2 :
                             (r_idx == 3'd3) ? STREAM_ID  : SC_PREFIX1;
                w_last_idx = 3'd3;
                w_next     = ST_PES_LEN;
            end
            ST_PES_LEN: begin
                w_hdr_byte = (r_idx == 3'd0) ? w_pes_len[15:8] : w_pes_len[7:0];
                w_last_idx = 3'd1;
                w_next     = ST_PES_TS;
            end
            ST_PES_TS: begin
                w_hdr_byte = r_pts_valid ? ts_byte(r_pts, r_idx, 4'b0010) : 8'h0F;
                w_last_idx = r_pts_valid ? 3'd4 : 3'd0;
                w_next     = ST_PAYLOAD;
            end
`ifdef MPEG_MUXER_END_CODE_EN
            ST_END_CODE: begin
                w_hdr_byte = (r_idx == 3'd2) ? SC_PREFIX2    :
                             (r_idx == 3'd3) ? END_CODE_BYTE : SC_PREFIX0;
                w_last_idx = 3'd3;
                w_next     = ST_IDLE;
            end
`endif
            default: begin
                w_hdr_byte = 8'h00;
                w_last_idx = 3'd0;
                w_next     = ST_IDLE;
            end
        endcase
    end

    // Payload is a zero-latency pass-through so ES flow control reaches downstream directly.
    assign out_valid   = (r_state == ST_PAYLOAD) ? es_valid : (r_state != ST_IDLE);
    assign out_data    = (r_state == ST_PAYLOAD) ? es_data  : w_hdr_byte;
    assign es_ready    = (r_state == ST_PAYLOAD) && out_ready;
    assign busy        = r_busy;
    assign packet_done = r_packet_done;
    assign w_hs        = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_idx         <= 3'd0;
            r_count       <= 16'd0;
            r_scr         <= 33'd0;
            r_pts         <= 33'd0;
            r_pts_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_packet_done <= 1'b0;
        end else begin
            r_packet_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_scr       <= scr;
                        r_pts       <= pts;
                        r_pts_valid <= pts_valid;
                        r_state     <= ST_PACK_SC;
                        r_idx       <= 3'd0;
                        r_busy      <= 1'b1;
                    end
`ifdef MPEG_MUXER_END_CODE_EN
                    else if (end_stream) begin
                        r_state <= ST_END_CODE;
                        r_idx   <= 3'd0;
                        r_busy  <= 1'b1;
                    end
`endif
                end
                ST_PAYLOAD: begin
                    if (es_valid && out_ready) begin
                        if (r_count == 16'd1) begin
                            r_state       <= ST_IDLE;
                            r_busy        <= 1'b0;
                            r_packet_done <= 1'b1;
                        end
                        r_count <= r_count - 16'd1;
                    end
                end
                default: begin
                    if (w_hs) begin
                        if (r_idx == w_last_idx) begin
                            r_state <= w_next;
                            r_idx   <= 3'd0;
                            if (w_next == ST_PAYLOAD) r_count <= PAYLOAD_LEN;
                            if (w_next == ST_IDLE)    r_busy  <= 1'b0;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mpeg_muxer.sv
// Scoreboard bench for mpeg_muxer with PAYLOAD_LEN=4: stimulus pushes expected bytes,
// a forked monitor pops and compares on every output handshake.
module tb_mpeg_muxer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [32:0] scr;
    logic [32:0] pts;
    logic        pts_valid;
    logic [7:0]  es_data;
    logic        es_valid;
    logic        es_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        packet_done;
    logic        end_stream;

    int checks = 0;
    int failures = 0;
    int byteNum = 0;
    int doneSeen = 0;
    int doneWant = 0;
    logic [7:0] expQ[$];
    logic [7:0] vec[$];
    logic [7:0] pay[$];

    mpeg_muxer #(.STREAM_ID(8'hE0), .PAYLOAD_LEN(16'd4), .MUX_RATE(22'd3528)) dut (
        .clk(clk), .reset(reset), .start(start), .scr(scr), .pts(pts),
        .pts_valid(pts_valid), .es_data(es_data), .es_valid(es_valid),
        .es_ready(es_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .packet_done(packet_done),
        .end_stream(end_stream)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [32:0] actual, input logic [32:0] want);
        checks++;
        if (actual !== want) begin
            failures++;
            $display("[TB] FAIL %s got %0h want %0h", name, actual, want);
        end
    endtask

    task automatic pushVec(input logic [7:0] v[$]);
        foreach (v[i]) expQ.push_back(v[i]);
    endtask

    // Monitor: runs on the falling edge, away from the DUT's active edge.
    task automatic monitorLoop();
        logic [7:0] want;
        forever begin
            @(negedge clk);
            if (!reset && packet_done) doneSeen++;
            if (!reset && out_valid && out_ready) begin
                checks++;
                if (expQ.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpectedByte[%0d] got %02h want none", byteNum, out_data);
                end else begin
                    want = expQ.pop_front();
                    if (out_data !== want) begin
                        failures++;
                        $display("[TB] FAIL streamByte[%0d] got %02h want %02h", byteNum, out_data, want);
                    end
                end
                byteNum++;
            end
        end
    endtask

    task automatic applyStimulus(input logic [32:0] s, input logic [32:0] p, input logic pv);
        scr = s; pts = p; pts_valid = pv; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Offers ES bytes; a gap of one cycle is inserted before byte index gapAt.
    task automatic feedPayload(input logic [7:0] bytes[$], input int gapAt, input bit expectDone);
        logic rdy;
        int waited;
        foreach (bytes[i]) begin
            if (i == gapAt) begin
                es_valid = 1'b0;
                @(negedge clk);
                checkOutput("gapOutValid", {32'd0, out_valid}, 33'd0);
                tick();
            end
            es_valid = 1'b1;
            es_data  = bytes[i];
            waited   = 0;
            do begin
                @(negedge clk);
                rdy = es_ready;
                tick();
                waited++;
            end while (!rdy && waited < 200);
            if (!rdy) begin
                checkOutput("esHandshakeTimeout", 33'd0, 33'd1);
                es_valid = 1'b0;
                return;
            end
        end
        es_valid = 1'b0;
        if (expectDone) begin
            doneWant++;
            @(negedge clk);
            checkOutput("packetDone", {32'd0, packet_done}, 33'd1);
            checkOutput("busyFallsWithDone", {32'd0, busy}, 33'd0);
        end
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        checkOutput(name, {32'd0, busy}, 33'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; scr = '0; pts = '0; pts_valid = 1'b0;
        es_data = 8'h00; es_valid = 1'b0; out_ready = 1'b1; end_stream = 1'b0;
        fork
            monitorLoop();
        join_none
        tick(); tick();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("resetOutValid", {32'd0, out_valid}, 33'd0);
        checkOutput("resetBusy", {32'd0, busy}, 33'd0);
        checkOutput("resetEsReady", {32'd0, es_ready}, 33'd0);
        checkOutput("resetPacketDone", {32'd0, packet_done}, 33'd0);
        tick();

        // Test 1: SCR and PTS zero
        vec = '{8'h00, 8'h00, 8'h01, 8'hBA, 8'h21, 8'h00, 8'h01, 8'h00, 8'h01, 8'h80, 8'h1B, 8'h91,
                8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h09, 8'h21, 8'h00, 8'h01, 8'h00, 8'h01,
                8'hAA, 8'hBB, 8'hCC, 8'hDD};
        pushVec(vec);
        applyStimulus(33'd0, 33'd0, 1'b1);
        @(negedge clk);
        checkOutput("busyAfterStart", {32'd0, busy}, 33'd1);
        pay = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        feedPayload(pay, -1, 1'b1);

        // Test 2: PTS=90000, started in the packet_done cycle; a start while busy is ignored
        vec = '{8'h00, 8'h00, 8'h01, 8'hBA, 8'h21, 8'h00, 8'h01, 8'h00, 8'h01, 8'h80, 8'h1B, 8'h91,
                8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h09, 8'h21, 8'h00, 8'h05, 8'hBF, 8'h21,
                8'h11, 8'h22, 8'h33, 8'h44};
        pushVec(vec);
        applyStimulus(33'd0, 33'd90000, 1'b1);
        @(negedge clk);
        checkOutput("startOnDoneAccepted", {32'd0, busy}, 33'd1);
        tick(); tick();
        applyStimulus(33'h1_2345_6789, 33'd7, 1'b0);
        pay = '{8'h11, 8'h22, 8'h33, 8'h44};
        feedPayload(pay, -1, 1'b1);
        tick();

        // Test 3: no PTS
        vec = '{8'h00, 8'h00, 8'h01, 8'hBA, 8'h21, 8'h00, 8'h01, 8'h00, 8'h01, 8'h80, 8'h1B, 8'h91,
                8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h05, 8'h0F,
                8'h01, 8'h02, 8'h03, 8'h04};
        pushVec(vec);
        applyStimulus(33'd0, 33'd90000, 1'b0);
        pay = '{8'h01, 8'h02, 8'h03, 8'h04};
        feedPayload(pay, -1, 1'b1);
        tick();

        // Test 4: header stall on pack byte 4, then an ES gap in the payload
        vec = '{8'h00, 8'h00, 8'h01, 8'hBA, 8'h21, 8'h00, 8'h01, 8'h00, 8'h01, 8'h80, 8'h1B, 8'h91,
                8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h09, 8'h21, 8'h00, 8'h01, 8'h00, 8'h01,
                8'h5A, 8'hA5, 8'hC3, 8'h3C};
        pushVec(vec);
        applyStimulus(33'd0, 33'd0, 1'b1);
        tick(); tick(); tick(); tick();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("stallData", {25'd0, out_data}, 33'h21);
            checkOutput("stallValid", {32'd0, out_valid}, 33'd1);
            tick();
        end
        out_ready = 1'b1;
        pay = '{8'h5A, 8'hA5, 8'hC3, 8'h3C};
        feedPayload(pay, 2, 1'b1);
        tick();

        // Test 5: reset after two payload bytes, then a fresh packet with extreme SCR
        vec = '{8'h00, 8'h00, 8'h01, 8'hBA, 8'h21, 8'h00, 8'h01, 8'h00, 8'h01, 8'h80, 8'h1B, 8'h91,
                8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h05, 8'h0F, 8'h77, 8'h88};
        pushVec(vec);
        applyStimulus(33'd0, 33'd0, 1'b0);
        pay = '{8'h77, 8'h88};
        feedPayload(pay, -1, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expQ.delete();
        @(negedge clk);
        checkOutput("midResetOutValid", {32'd0, out_valid}, 33'd0);
        checkOutput("midResetBusy", {32'd0, busy}, 33'd0);
        tick();
        vec = '{8'h00, 8'h00, 8'h01, 8'hBA, 8'h2F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h80, 8'h1B, 8'h91,
                8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h09, 8'h21, 8'h00, 8'h05, 8'hBF, 8'h21,
                8'hDE, 8'hAD, 8'hBE, 8'hEF};
        pushVec(vec);
        applyStimulus(33'h1_FFFF_FFFF, 33'd90000, 1'b1);
        pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        feedPayload(pay, -1, 1'b1);
        tick();

`ifdef MPEG_MUXER_END_CODE_EN
        // Test 6: end code
        vec = '{8'h00, 8'h00, 8'h01, 8'hB9};
        pushVec(vec);
        end_stream = 1'b1;
        tick();
        end_stream = 1'b0;
        @(negedge clk);
        checkOutput("endCodeBusy", {32'd0, busy}, 33'd1);
        waitIdle("endCodeDone");
`else
        // Test 6: without the end code feature end_stream does nothing
        end_stream = 1'b1;
        tick();
        end_stream = 1'b0;
        @(negedge clk);
        checkOutput("endStreamIgnoredBusy", {32'd0, busy}, 33'd0);
        checkOutput("endStreamIgnoredValid", {32'd0, out_valid}, 33'd0);
`endif
        tick(); tick(); tick();
        checkOutput("scoreboardDrained", expQ.size(), 33'd0);
        checkOutput("packetDoneCount", doneSeen, doneWant);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout got running want finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
